// File: rtl/cordic_rot_core.sv
// Iterative rotation-mode CORDIC: folds an 8-bit binary angle into [-pi/2, pi/2),
// runs ITER micro-rotations, and emits Q1.6 cos/sin plus a negate flag.
module cordic_rot_core #(
    parameter int ITER  = 8,
    parameter int GUARD = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] angle_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] cos_out,
    output logic [7:0] sin_out,
    output logic       neg_flag
);

    localparam int W   = 8 + GUARD + 1;
    localparam int RW  = W + 1;
    localparam int ZW  = 12;
    localparam int RND = (1 << GUARD) >> 1;

    localparam logic signed [RW-1:0] SAT_MAX = RW'(127);
    localparam logic signed [RW-1:0] SAT_MIN = -RW'(128);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic logic signed [W-1:0] k_init(input int g);
        case (g)
            0:       k_init = W'(39);
            1:       k_init = W'(78);
            2:       k_init = W'(155);
            3:       k_init = W'(311);
            default: k_init = W'(622);
        endcase
    endfunction

    function automatic logic signed [ZW-1:0] atan_lut(input logic [2:0] idx);
        case (idx)
            3'd0:    atan_lut = 12'sd512;
            3'd1:    atan_lut = 12'sd302;
            3'd2:    atan_lut = 12'sd160;
            3'd3:    atan_lut = 12'sd81;
            3'd4:    atan_lut = 12'sd41;
            3'd5:    atan_lut = 12'sd20;
            3'd6:    atan_lut = 12'sd10;
            default: atan_lut = 12'sd5;
        endcase
    endfunction

    // Round off the guard bits, then clamp to the signed 8-bit range.
    function automatic logic [7:0] sat8(input logic signed [W-1:0] v);
        logic signed [RW-1:0] r;
        r = $signed({v[W-1], v}) + $signed(RW'(RND));
        r = r >>> GUARD;
        if (r > SAT_MAX)      sat8 = 8'h7F;
        else if (r < SAT_MIN) sat8 = 8'h80;
        else                  sat8 = r[7:0];
    endfunction

    localparam logic signed [W-1:0] X_INIT = k_init(GUARD);

    state_t                state_q, state_d;
    logic signed [W-1:0]   x_q, x_d;
    logic signed [W-1:0]   y_q, y_d;
    logic signed [ZW-1:0]  z_q, z_d;
    logic [2:0]            i_q, i_d;
    logic                  neg_q, neg_d;
    logic [7:0]            cos_q, cos_d;
    logic [7:0]            sin_q, sin_d;
    logic                  flag_q, flag_d;

    logic signed [W-1:0]   x_sh, y_sh;
    logic signed [ZW-1:0]  atan_i;
    logic                  fold;
    logic [7:0]            a_fold;

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign cos_out   = cos_q;
    assign sin_out   = sin_q;
    assign neg_flag  = flag_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        i_d     = i_q;
        neg_d   = neg_q;
        cos_d   = cos_q;
        sin_d   = sin_q;
        flag_d  = flag_q;

        x_sh    = x_q >>> i_q;
        y_sh    = y_q >>> i_q;
        atan_i  = atan_lut(i_q);
        fold    = angle_in[7] ^ angle_in[6];
        a_fold  = fold ? (angle_in ^ 8'h80) : angle_in;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    x_d     = X_INIT;
                    y_d     = '0;
                    z_d     = {a_fold, 4'b0000};
                    i_d     = '0;
                    neg_d   = fold;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (z_q[ZW-1]) begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + atan_i;
                end else begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - atan_i;
                end
                i_d = i_q + 3'd1;
                if (i_q == 3'(ITER - 1)) begin
                    cos_d   = sat8(x_d);
                    sin_d   = sat8(y_d);
                    flag_d  = neg_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            i_q     <= '0;
            neg_q   <= 1'b0;
            cos_q   <= '0;
            sin_q   <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            i_q     <= i_d;
            neg_q   <= neg_d;
            cos_q   <= cos_d;
            sin_q   <= sin_d;
            flag_q  <= flag_d;
        end
    end

endmodule
